carregador_matriz: RTL

CARREGADOR_MATRIZ -- requirements
Module: carregador_matriz

---
 rtl/carregador_matriz.sv | 118 +++++++++++
 1 files changed

// File: rtl/carregador_matriz.sv
// Assembles a row-major stream of signed elements into a flat n x n matrix (n = 2..5).
// Optional macro CARREGADOR_ZERO_FILL_EN clears every slot when a load is accepted.
module carregador_matriz #(
  parameter int ELEM_W  = 8,
  parameter int MAX_DIM = 5
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic [1:0]                          matrix_size,
  input  logic [ELEM_W-1:0]                   in_data,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic [MAX_DIM*MAX_DIM*ELEM_W-1:0]   matriz_A,
  output logic                                matriz_valid,
  input  logic                                matriz_ack,
  output logic                                busy,
  output logic [$clog2(MAX_DIM*MAX_DIM+1)-1:0] elem_count
);

  localparam int SLOTS = MAX_DIM * MAX_DIM;
  localparam int CNT_W = $clog2(SLOTS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t     state_r;
  logic [1:0] size_r;
  logic [CNT_W-1:0] total_s;
  logic [CNT_W-1:0] last_idx_s;
  logic             fire_s;

  // Dimension code 0..3 maps to n = 2..5; returns n*n.
  function automatic logic [CNT_W-1:0] total_elems(input logic [1:0] code);
    logic [CNT_W-1:0] dim;
    dim = CNT_W'(code) + CNT_W'(2);
    return CNT_W'(dim * dim);
  endfunction

  // Element count for the latched size and the handshake qualifier.
  always_comb begin
    total_s    = total_elems(size_r);
    last_idx_s = total_s - CNT_W'(1);
    fire_s     = in_valid && in_ready;
  end

  // Load FSM; every output is a register updated with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      size_r       <= 2'b00;
      matriz_A     <= '0;
      matriz_valid <= 1'b0;
      in_ready     <= 1'b0;
      busy         <= 1'b0;
      elem_count   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            size_r       <= matrix_size;
            elem_count   <= '0;
`ifdef CARREGADOR_ZERO_FILL_EN
            matriz_A     <= '0;
`else
            matriz_A     <= matriz_A;
`endif
            in_ready     <= 1'b1;
            busy         <= 1'b1;
            matriz_valid <= 1'b0;
            state_r      <= LOAD;
          end else begin
            state_r <= IDLE;
          end
        end
        LOAD: begin
          if (fire_s) begin
            // Slots beyond n*n are excluded so stale data there is never overwritten.
            for (int k = 0; k < SLOTS; k++) begin
              if ((elem_count == CNT_W'(k)) && (elem_count < total_s)) begin
                matriz_A[k*ELEM_W +: ELEM_W] <= in_data;
              end
            end
            elem_count <= elem_count + CNT_W'(1);
            if (elem_count == last_idx_s) begin
              in_ready     <= 1'b0;
              matriz_valid <= 1'b1;
              state_r      <= DONE;
            end else begin
              state_r <= LOAD;
            end
          end else begin
            state_r <= LOAD;
          end
        end
        DONE: begin
          if (matriz_ack) begin
            matriz_valid <= 1'b0;
            busy         <= 1'b0;
            state_r      <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r      <= IDLE;
          matriz_valid <= 1'b0;
          in_ready     <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule
